// File: rtl/dht11_sensor_emu.sv
// DHT11 responder: waits for a host start pulse on the open-drain bus, then sends
// ACK, a 40-bit humidity/temperature payload with checksum, and the end bit.
module dht11_sensor_emu #(
   parameter int MIN_START_LOW_US = 1000,
   parameter int RESP_DELAY_US    = 30,
   parameter int ACK_LOW_US       = 80,
   parameter int ACK_HIGH_US      = 80,
   parameter int BIT_LOW_US       = 50,
   parameter int BIT0_HIGH_US     = 28,
   parameter int BIT1_HIGH_US     = 70
) (
   input  logic       iClk,
   input  logic       iRstn,
   input  logic       iTickUs,
   inout  wire        ioData,
   input  logic [7:0] iHumInt,
   input  logic [7:0] iHumDec,
   input  logic [7:0] iTempInt,
   input  logic [7:0] iTempDec,
   input  logic       iChkErr,
   output logic       oBusy,
   output logic       oFrameDone,
   output logic       oStartErr
);

   localparam int CW = $clog2(MIN_START_LOW_US + RESP_DELAY_US + ACK_LOW_US + ACK_HIGH_US +
                              BIT_LOW_US + BIT0_HIGH_US + BIT1_HIGH_US + 1);

   localparam logic [CW-1:0] C_MIN   = CW'(MIN_START_LOW_US);
   localparam logic [CW-1:0] C_RESP  = CW'(RESP_DELAY_US);
   localparam logic [CW-1:0] C_ACKL  = CW'(ACK_LOW_US);
   localparam logic [CW-1:0] C_ACKH  = CW'(ACK_HIGH_US);
   localparam logic [CW-1:0] C_BITL  = CW'(BIT_LOW_US);
   localparam logic [CW-1:0] C_BIT0H = CW'(BIT0_HIGH_US);
   localparam logic [CW-1:0] C_BIT1H = CW'(BIT1_HIGH_US);

   typedef enum logic [3:0] {
      S_IDLE,
      S_START_LOW,
      S_RESP_DELAY,
      S_ACK_LOW,
      S_ACK_HIGH,
      S_BIT_LOW,
      S_BIT_HIGH,
      S_END_LOW,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_usCnt;
   logic [1:0]      r_sync;
   logic [39:0]     r_payload;
   logic [5:0]      r_bitIdx;
   logic            r_drvLow;
   logic            r_busy;
   logic            r_frameDone;
   logic            r_startErr;

   logic            w_busS;
   logic [7:0]      w_sum;
   logic [CW-1:0]   w_bitHighUs;

   assign w_busS      = r_sync[1];
   assign w_sum       = iHumInt + iHumDec + iTempInt + iTempDec;
   assign w_bitHighUs = r_payload[39] ? C_BIT1H : C_BIT0H;

   assign ioData     = r_drvLow ? 1'b0 : 1'bz;
   assign oBusy      = r_busy;
   assign oFrameDone = r_frameDone;
   assign oStartErr  = r_startErr;

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         r_state     <= S_IDLE;
         r_usCnt     <= '0;
         r_sync      <= 2'b11;
         r_payload   <= '0;
         r_bitIdx    <= '0;
         r_drvLow    <= 1'b0;
         r_busy      <= 1'b0;
         r_frameDone <= 1'b0;
         r_startErr  <= 1'b0;
      end else begin
         r_frameDone <= 1'b0;
         r_startErr  <= 1'b0;

         // Outside start detection the synchronizer is held high so our own
         // end-bit low cannot reappear in IDLE as a phantom host start.
         if (r_state == S_IDLE || r_state == S_START_LOW)
            r_sync <= {r_sync[0], ioData};
         else
            r_sync <= 2'b11;

         if (iTickUs)
            r_usCnt <= r_usCnt + 1'b1;

         case (r_state)
            S_IDLE: begin
               r_usCnt <= '0;
               if (!w_busS)
                  r_state <= S_START_LOW;
            end

            S_START_LOW: begin
               if (w_busS) begin
                  r_usCnt <= '0;
                  if (r_usCnt >= C_MIN) begin
                     r_state   <= S_RESP_DELAY;
                     r_busy    <= 1'b1;
                     r_payload <= {iHumInt, iHumDec, iTempInt, iTempDec,
                                   iChkErr ? ~w_sum : w_sum};
                  end else begin
                     r_state    <= S_IDLE;
                     r_startErr <= 1'b1;
                  end
               end else if (r_usCnt >= C_MIN) begin
                  r_usCnt <= C_MIN;
               end
            end

            S_RESP_DELAY: begin
               if (r_usCnt == C_RESP) begin
                  r_usCnt  <= '0;
                  r_state  <= S_ACK_LOW;
                  r_drvLow <= 1'b1;
               end
            end

            S_ACK_LOW: begin
               if (r_usCnt == C_ACKL) begin
                  r_usCnt  <= '0;
                  r_state  <= S_ACK_HIGH;
                  r_drvLow <= 1'b0;
               end
            end

            S_ACK_HIGH: begin
               if (r_usCnt == C_ACKH) begin
                  r_usCnt  <= '0;
                  r_state  <= S_BIT_LOW;
                  r_drvLow <= 1'b1;
                  r_bitIdx <= '0;
               end
            end

            S_BIT_LOW: begin
               if (r_usCnt == C_BITL) begin
                  r_usCnt  <= '0;
                  r_state  <= S_BIT_HIGH;
                  r_drvLow <= 1'b0;
               end
            end

            // The current bit is always payload[39]; the register shifts after each bit.
            S_BIT_HIGH: begin
               if (r_usCnt == w_bitHighUs) begin
                  r_usCnt   <= '0;
                  r_drvLow  <= 1'b1;
                  r_payload <= {r_payload[38:0], 1'b0};
                  if (r_bitIdx == 6'd39) begin
                     r_state <= S_END_LOW;
                  end else begin
                     r_state  <= S_BIT_LOW;
                     r_bitIdx <= r_bitIdx + 6'd1;
                  end
               end
            end

            S_END_LOW: begin
               if (r_usCnt == C_BITL) begin
                  r_usCnt  <= '0;
                  r_state  <= S_DONE;
                  r_drvLow <= 1'b0;
                  r_busy   <= 1'b0;
               end
            end

            S_DONE: begin
               r_usCnt     <= '0;
               r_frameDone <= 1'b1;
               r_state     <= S_IDLE;
            end

            default: begin
               r_usCnt  <= '0;
               r_state  <= S_IDLE;
               r_drvLow <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Bench for dht11_sensor_emu: acts as the DHT host, measures every bus phase and
// checks it against a frame model built from the byte values and protocol widths.
module tb_dht11_sensor_emu;

   // A tick every 2 clocks and a 200us minimum start keep the run short.
   localparam int TP        = 2;
   localparam int MIN_START = 200;
   localparam int RESP_US   = 30;
   localparam int ACKL_US   = 80;
   localparam int ACKH_US   = 80;
   localparam int BITL_US   = 50;
   localparam int BIT0_US   = 28;
   localparam int BIT1_US   = 70;
   localparam int RUN_LIMIT = 4000;

   logic       iClk = 1'b0;
   logic       iRstn;
   logic       iTickUs;
   logic [7:0] iHumInt, iHumDec, iTempInt, iTempDec;
   logic       iChkErr;
   logic       oBusy, oFrameDone, oStartErr;
   logic       host_low = 1'b0;
   wire        ioData;

   int n_checks = 0;
   int n_errs   = 0;
   int n_done   = 0;
   int n_serr   = 0;
   logic drive_seen = 1'b0;
   logic busy_seen  = 1'b0;

   pullup (ioData);
   assign ioData = host_low ? 1'b0 : 1'bz;

   dht11_sensor_emu #(
      .MIN_START_LOW_US(MIN_START),
      .RESP_DELAY_US   (RESP_US),
      .ACK_LOW_US      (ACKL_US),
      .ACK_HIGH_US     (ACKH_US),
      .BIT_LOW_US      (BITL_US),
      .BIT0_HIGH_US    (BIT0_US),
      .BIT1_HIGH_US    (BIT1_US)
   ) dut (
      .iClk      (iClk),
      .iRstn     (iRstn),
      .iTickUs   (iTickUs),
      .ioData    (ioData),
      .iHumInt   (iHumInt),
      .iHumDec   (iHumDec),
      .iTempInt  (iTempInt),
      .iTempDec  (iTempDec),
      .iChkErr   (iChkErr),
      .oBusy     (oBusy),
      .oFrameDone(oFrameDone),
      .oStartErr (oStartErr)
   );

   always #5 iClk = ~iClk;

   initial begin
      iTickUs = 1'b0;
      forever begin
         repeat (TP - 1) @(posedge iClk);
         #1 iTickUs = 1'b1;
         @(posedge iClk);
         #1 iTickUs = 1'b0;
      end
   end

   always @(negedge iClk) begin
      if (oFrameDone) n_done <= n_done + 1;
      if (oStartErr)  n_serr <= n_serr + 1;
      if (!host_low && ioData === 1'b0) drive_seen <= 1'b1;
      if (oBusy) busy_seen <= 1'b1;
   end

   initial begin
      #20ms;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      n_checks++;
      assert ((obs >= lo && obs <= hi) === 1'b1) else begin
         n_errs++;
         $error("FAIL %s observed=%0d expected=%0d..%0d cycles", tag, obs, lo, hi);
      end
   endtask

   // A phase of N us lasts between (N-1)*TP+2 and N*TP+1 clocks depending on tick phase.
   function automatic int lo_cyc(input int us);
      return us * TP - TP + 2;
   endfunction

   function automatic int hi_cyc(input int us);
      return us * TP + 1;
   endfunction

   function automatic logic bus_lvl();
      return (ioData === 1'b0) ? 1'b0 : 1'b1;
   endfunction

   function automatic logic [39:0] exp_frame(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d,
                                             input logic err);
      logic [7:0] s;
      s = a + b + c + d;
      if (err) s = ~s;
      return {a, b, c, d, s};
   endfunction

   task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input logic err);
      iHumInt  = a;
      iHumDec  = b;
      iTempInt = c;
      iTempDec = d;
      iChkErr  = err;
   endtask

   task automatic set_random_bytes();
      set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
   endtask

   // Counts consecutive falling-edge samples at level lvl; called on a negedge.
   task automatic run_len(input logic lvl, output int cyc, output bit to);
      cyc = 0;
      to  = 1'b0;
      while (bus_lvl() == lvl) begin
         cyc++;
         @(negedge iClk);
         if (cyc > RUN_LIMIT) begin
            to = 1'b1;
            break;
         end
      end
   endtask

   task automatic host_start(input int low_us);
      @(posedge iClk);
      #1 host_low = 1'b1;
      repeat (low_us * TP) @(posedge iClk);
      #1 host_low = 1'b0;
      @(negedge iClk);
   endtask

   // Receives one frame right after host release; abort_at >= 0 resets the DUT
   // during that bit's high phase instead of finishing the frame.
   task automatic rx_frame(input logic [39:0] ev, input string tag, input int abort_at,
                           output logic [39:0] dec);
      int  c;
      bit  to;
      int  done0;
      int  lows;
      int  exp_us;
      done0 = n_done;
      dec   = '0;

      run_len(1'b1, c, to);
      chk_rng({tag, "_resp"}, c, lo_cyc(RESP_US) + 2, hi_cyc(RESP_US) + 4);
      if (to) return;
      chk({tag, "_busy_ack"}, int'(oBusy), 1);
      run_len(1'b0, c, to);
      chk_rng({tag, "_ackl"}, c, lo_cyc(ACKL_US), hi_cyc(ACKL_US));
      if (to) return;
      run_len(1'b1, c, to);
      chk_rng({tag, "_ackh"}, c, lo_cyc(ACKH_US), hi_cyc(ACKH_US));
      if (to) return;
      set_random_bytes();

      for (int i = 0; i < 40; i++) begin
         run_len(1'b0, c, to);
         chk_rng($sformatf("%s_b%0d_low", tag, i), c, lo_cyc(BITL_US), hi_cyc(BITL_US));
         if (to) return;
         if (i == abort_at) begin
            repeat (10) @(negedge iClk);
            iRstn = 1'b0;
            #1;
            chk({tag, "_rst_bus"}, int'(bus_lvl()), 1);
            chk({tag, "_rst_busy"}, int'(oBusy), 0);
            lows = 0;
            repeat (400) begin
               @(negedge iClk);
               if (ioData === 1'b0) lows++;
            end
            chk({tag, "_rst_quiet"}, lows, 0);
            chk({tag, "_rst_nodone"}, n_done - done0, 0);
            iRstn = 1'b1;
            return;
         end
         exp_us = ev[39 - i] ? BIT1_US : BIT0_US;
         run_len(1'b1, c, to);
         chk_rng($sformatf("%s_b%0d_high", tag, i), c, lo_cyc(exp_us), hi_cyc(exp_us));
         if (to) return;
         dec[39 - i] = (c > ((BIT0_US + BIT1_US) * TP) / 2);
      end

      run_len(1'b0, c, to);
      chk_rng({tag, "_end_low"}, c, lo_cyc(BITL_US), hi_cyc(BITL_US));
      if (to) return;
      repeat (6) @(negedge iClk);
      chk({tag, "_done_cnt"}, n_done - done0, 1);
      chk({tag, "_busy_end"}, int'(oBusy), 0);
      for (int k = 0; k < 5; k++)
         chk($sformatf("%s_byte%0d", tag, k), int'(dec[39 - 8*k -: 8]), int'(ev[39 - 8*k -: 8]));
   endtask

   initial begin
      logic [39:0] ev;
      logic [39:0] dec;
      int          serr0;

      set_bytes(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      iRstn = 1'b0;
      repeat (5) @(negedge iClk);
      chk("rst_bus", int'(bus_lvl()), 1);
      chk("rst_busy", int'(oBusy), 0);
      chk("rst_done", int'(oFrameDone), 0);
      chk("rst_serr", int'(oStartErr), 0);
      iRstn = 1'b1;
      repeat (10) @(negedge iClk);

      // Short start: below the minimum width, no response expected.
      serr0      = n_serr;
      drive_seen = 1'b0;
      busy_seen  = 1'b0;
      host_start(MIN_START / 2);
      repeat (300) @(negedge iClk);
      chk("short_serr", n_serr - serr0, 1);
      chk("short_drive", int'(drive_seen), 0);
      chk("short_busy", int'(busy_seen), 0);
      chk("short_nodone", n_done, 0);

      // Bit timing frame: first bit 1, bits 2..8 zero, checksum 0x81.
      set_bytes(8'h80, 8'h00, 8'h00, 8'h01, 1'b0);
      ev = exp_frame(8'h80, 8'h00, 8'h00, 8'h01, 1'b0);
      host_start(MIN_START + 50);
      rx_frame(ev, "bt", -1, dec);
      chk("bt_chk81", int'(dec[7:0]), 8'h81);
      repeat (20) @(negedge iClk);

      // Checksum injection: 55/0/24/0 sums to 0x4F, sent inverted.
      set_bytes(8'd55, 8'd0, 8'd24, 8'd0, 1'b1);
      ev = exp_frame(8'd55, 8'd0, 8'd24, 8'd0, 1'b1);
      host_start(MIN_START + 50);
      rx_frame(ev, "ce", -1, dec);
      chk("ce_chkB0", int'(dec[7:0]), 8'hB0);
      repeat (20) @(negedge iClk);

      // Back-to-back frames with random payloads.
      for (int f = 0; f < 2; f++) begin
         set_random_bytes();
         ev = exp_frame(iHumInt, iHumDec, iTempInt, iTempDec, iChkErr);
         host_start(MIN_START + 50);
         rx_frame(ev, $sformatf("b2b%0d", f), -1, dec);
         repeat (20) @(negedge iClk);
      end

      // Reset during bit 20 high, then a clean frame.
      set_random_bytes();
      ev = exp_frame(iHumInt, iHumDec, iTempInt, iTempDec, iChkErr);
      host_start(MIN_START + 50);
      rx_frame(ev, "abort", 20, dec);
      repeat (20) @(negedge iClk);

      set_random_bytes();
      ev = exp_frame(iHumInt, iHumDec, iTempInt, iTempDec, iChkErr);
      host_start(MIN_START + 50);
      rx_frame(ev, "post", -1, dec);
      repeat (20) @(negedge iClk);
      chk("total_done", n_done, 5);
      chk("total_serr", n_serr, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
